// File: rtl/mem_lsu_pkg.sv
// mem_lsu_pkg: shared definitions for the mem_lsu load/store unit.
//   - Size encodings carried on req_size_i.
//   - FSM state enumeration used by mem_lsu.
//   - Base byte-mask constants (unshifted, lane 0 aligned).
//   - size_bytes(): number of bytes touched by a given size encoding.
package mem_lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    localparam logic [3:0] MASK_NONE = 4'b0000;
    localparam logic [3:0] MASK_BYTE = 4'b0001;
    localparam logic [3:0] MASK_HALF = 4'b0011;
    localparam logic [3:0] MASK_WORD = 4'b1111;

    // StIssueHi/StWaitHi are only reachable with MEM_LSU_MISALIGN_SPLIT_EN.
    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StResp,
        StIssueHi,
        StWaitHi
    } state_t;

    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SZ_BYTE: return 3'd1;
            SZ_HALF: return 3'd2;
            SZ_WORD: return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// mem_lsu_align: purely combinational lane steering and load extraction.
//   size        in   2   request size encoding
//   offset      in   2   byte offset within the first word
//   is_unsigned in   1   zero-extend (1) or sign-extend (0) loads
//   wdata       in  32   right-aligned store data
//   rdata       in  64   {hi word, lo word} of raw RAM read data
//   mask_lo/hi  out  4   byte masks for the first / following word
//   wdata_lo/hi out 32   store data steered onto the first / following word
//   rdata_ext   out 32   extracted and extended load data
// Treating the access as a 64-bit window lets the same logic serve both the
// single-word case (hi half unused) and a word-crossing split access.
module mem_lsu_align
    import mem_lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [63:0] rdata,
    output logic [3:0]  mask_lo,
    output logic [3:0]  mask_hi,
    output logic [31:0] wdata_lo,
    output logic [31:0] wdata_hi,
    output logic [31:0] rdata_ext
);

    logic [3:0]  base_mask;
    logic [7:0]  mask8;
    logic [63:0] wdata64;
    logic [31:0] rsh;

    always_comb begin
        case (size)
            SZ_BYTE: base_mask = MASK_BYTE;
            SZ_HALF: base_mask = MASK_HALF;
            SZ_WORD: base_mask = MASK_WORD;
            default: base_mask = MASK_NONE;
        endcase

        mask8   = {4'b0000, base_mask} << offset;
        wdata64 = {32'h0000_0000, wdata} << {offset, 3'b000};
        rsh     = 32'(rdata >> {offset, 3'b000});

        mask_lo  = mask8[3:0];
        mask_hi  = mask8[7:4];
        wdata_lo = wdata64[31:0];
        wdata_hi = wdata64[63:32];

        case (size)
            SZ_BYTE: rdata_ext = {{24{~is_unsigned & rsh[7]}}, rsh[7:0]};
            SZ_HALF: rdata_ext = {{16{~is_unsigned & rsh[15]}}, rsh[15:0]};
            SZ_WORD: rdata_ext = rsh;
            default: rdata_ext = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: load/store unit in front of a word-organised synchronous RAM.
// Accepts byte-addressed byte/half/word requests over valid/ready, drives one
// (or, for a split access, two) RAM cycles and returns a one-cycle response.
//   clk, reset_n             clock, synchronous active-low reset
//   req_valid_i/req_ready_o  request handshake (ready only when idle)
//   req_we_i, req_addr_i, req_size_i, req_unsigned_i, req_wdata_i  request
//   rsp_valid_o, rsp_rdata_o, rsp_err_o   response pulse, no backpressure
//   ram_en_n_o, ram_addr_o, ram_wdata_o, ram_wr_mask_o, ram_rdata_i  RAM side
// Build option MEM_LSU_MISALIGN_SPLIT_EN: misaligned accesses become legal and
// a word-crossing access is split into two RAM cycles (lo word, then hi word).
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned DEPTH     = 1024
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        ram_en_n_o,
    output logic [31:0] ram_addr_o,
    output logic [31:0] ram_wdata_o,
    output logic [3:0]  ram_wr_mask_o,
    input  logic [31:0] ram_rdata_i
);

    localparam logic [33:0] LIMIT = 34'(DEPTH) << 2;

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic [1:0]  off_q, off_d;
    logic        uns_q, uns_d;
    logic        cross_q, cross_d;
    logic        err_q, err_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] word_q, word_d;
    logic [31:0] data_q, data_d;
    logic [31:0] lo_q, lo_d;

    // Accept-time decode of the incoming request.
    logic [31:0] rel;
    logic [2:0]  nbytes;
    logic [33:0] end_excl;
    logic        acc_err;
    logic        acc_cross;

    always_comb begin
        rel      = req_addr_i - BASE_ADDR;
        nbytes   = size_bytes(req_size_i);
        // One past the last byte; 34 bits so the sum cannot wrap.
        end_excl = {2'b00, rel} + {31'b0, nbytes};
        acc_err  = (req_size_i == SZ_ILL) || (req_addr_i < BASE_ADDR) || (end_excl > LIMIT);
`ifdef MEM_LSU_MISALIGN_SPLIT_EN
        acc_cross = ({1'b0, rel[1:0]} + nbytes) > 3'd4;
`else
        acc_cross = 1'b0;
        if ((req_size_i == SZ_HALF && rel[0]) ||
            (req_size_i == SZ_WORD && rel[1:0] != 2'b00)) begin
            acc_err = 1'b1;
        end
`endif
    end

    logic [3:0]  mask_lo, mask_hi;
    logic [31:0] wdata_lo, wdata_hi, rdata_ext;
    logic [63:0] rdata_cat;

    // Second half of a split load pairs the fresh hi word with the saved lo word.
    assign rdata_cat = (state_q == StWaitHi) ? {ram_rdata_i, lo_q} : {32'h0000_0000, ram_rdata_i};

    mem_lsu_align u_align (
        .size        (size_q),
        .offset      (off_q),
        .is_unsigned (uns_q),
        .wdata       (wdata_q),
        .rdata       (rdata_cat),
        .mask_lo     (mask_lo),
        .mask_hi     (mask_hi),
        .wdata_lo    (wdata_lo),
        .wdata_hi    (wdata_hi),
        .rdata_ext   (rdata_ext)
    );

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        off_d   = off_q;
        uns_d   = uns_q;
        cross_d = cross_q;
        err_d   = err_q;
        wdata_d = wdata_q;
        word_d  = word_q;
        data_d  = data_q;
        lo_d    = lo_q;

        ram_en_n_o    = 1'b1;
        ram_addr_o    = 32'h0000_0000;
        ram_wdata_o   = 32'h0000_0000;
        ram_wr_mask_o = MASK_NONE;

        case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    we_d    = req_we_i;
                    size_d  = req_size_i;
                    off_d   = rel[1:0];
                    uns_d   = req_unsigned_i;
                    wdata_d = req_wdata_i;
                    word_d  = {2'b00, rel[31:2]};
                    cross_d = acc_cross;
                    err_d   = acc_err;
                    data_d  = 32'h0000_0000;
                    state_d = acc_err ? StResp : StIssue;
                end
            end
            StIssue: begin
                ram_en_n_o = 1'b0;
                ram_addr_o = word_q;
                if (we_q) begin
                    ram_wr_mask_o = mask_lo;
                    ram_wdata_o   = wdata_lo;
                    state_d       = cross_q ? StIssueHi : StResp;
                end else begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (cross_q) begin
                    lo_d    = ram_rdata_i;
                    state_d = StIssueHi;
                end else begin
                    data_d  = rdata_ext;
                    state_d = StResp;
                end
            end
            StIssueHi: begin
                ram_en_n_o = 1'b0;
                ram_addr_o = word_q + 32'd1;
                if (we_q) begin
                    ram_wr_mask_o = mask_hi;
                    ram_wdata_o   = wdata_hi;
                    state_d       = StResp;
                end else begin
                    state_d = StWaitHi;
                end
            end
            StWaitHi: begin
                data_d  = rdata_ext;
                state_d = StResp;
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign req_ready_o = (state_q == StIdle);
    assign rsp_valid_o = (state_q == StResp);
    assign rsp_err_o   = (state_q == StResp) && err_q;
    assign rsp_rdata_o = (state_q == StResp) ? data_q : 32'h0000_0000;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= StIdle;
            we_q    <= 1'b0;
            size_q  <= SZ_BYTE;
            off_q   <= 2'b00;
            uns_q   <= 1'b0;
            cross_q <= 1'b0;
            err_q   <= 1'b0;
            wdata_q <= 32'h0000_0000;
            word_q  <= 32'h0000_0000;
            data_q  <= 32'h0000_0000;
            lo_q    <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            off_q   <= off_d;
            uns_q   <= uns_d;
            cross_q <= cross_d;
            err_q   <= err_d;
            wdata_q <= wdata_d;
            word_q  <= word_d;
            data_q  <= data_d;
            lo_q    <= lo_d;
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed bench for mem_lsu with a byte-level reference model.
// The model keeps a flat byte array, predicts each response and every RAM
// cycle by cycle number, and one compare process checks the DUT each cycle.
`timescale 1ns/1ps
module tb_mem_lsu;

    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int          DEP  = 16;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [1:0]  req_size = '0;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        ram_en_n;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [3:0]  ram_wr_mask;
    logic [31:0] ram_rdata = '0;

    mem_lsu #(
        .BASE_ADDR (BASE),
        .DEPTH     (DEP)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_we_i       (req_we),
        .req_addr_i     (req_addr),
        .req_size_i     (req_size),
        .req_unsigned_i (req_unsigned),
        .req_wdata_i    (req_wdata),
        .rsp_valid_o    (rsp_valid),
        .rsp_rdata_o    (rsp_rdata),
        .rsp_err_o      (rsp_err),
        .ram_en_n_o     (ram_en_n),
        .ram_addr_o     (ram_addr),
        .ram_wdata_o    (ram_wdata),
        .ram_wr_mask_o  (ram_wr_mask),
        .ram_rdata_i    (ram_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM environment: synchronous read, byte-masked write.
    logic [31:0] ram [DEP] = '{default: 32'h0};
    always @(posedge clk) begin
        if (!ram_en_n) begin
            if (ram_addr < 32'(DEP)) begin
                ram_rdata <= ram[ram_addr[3:0]];
                for (int b = 0; b < 4; b++)
                    if (ram_wr_mask[b]) ram[ram_addr[3:0]][8*b +: 8] <= ram_wdata[8*b +: 8];
            end else begin
                ram_rdata <= 32'hDEAD_BEEF;
            end
        end
    end

    // Reference model state.
    logic [7:0]  ref_mem [4*DEP] = '{default: 8'h0};
    bit          exp_rv [int];
    logic [31:0] exp_rd [int];
    logic        exp_re [int];
    bit          exp_busy [int];
    logic [31:0] exp_aw [int];
    logic [3:0]  exp_am [int];
    logic [31:0] exp_ad [int];
    int          free_cyc = 0;
    bit          chk_en = 1'b0;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("req_ready", 32'(req_ready), exp_busy.exists(cyc) ? 32'd0 : 32'd1);
            if (exp_rv.exists(cyc)) begin
                chk("rsp_valid", 32'(rsp_valid), 32'd1);
                chk("rsp_rdata", rsp_rdata, exp_rd[cyc]);
                chk("rsp_err", 32'(rsp_err), 32'(exp_re[cyc]));
            end else begin
                chk("rsp_valid_idle", 32'(rsp_valid), 32'd0);
            end
            if (exp_am.exists(cyc)) begin
                logic [31:0] lanes;
                for (int b = 0; b < 4; b++) lanes[8*b +: 8] = {8{exp_am[cyc][b]}};
                chk("ram_en_n", 32'(ram_en_n), 32'd0);
                chk("ram_addr", ram_addr, exp_aw[cyc]);
                chk("ram_mask", 32'(ram_wr_mask), 32'(exp_am[cyc]));
                chk("ram_wdata", ram_wdata & lanes, exp_ad[cyc] & lanes);
            end else begin
                chk("ram_en_n_idle", 32'(ram_en_n), 32'd1);
                chk("ram_mask_idle", 32'(ram_wr_mask), 32'd0);
            end
        end
    end

    // Drive one request (waiting until the model says the unit is idle) and
    // record the model's predictions. Returns #1 after the accept edge.
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [1:0] size,
                          input logic uns, input logic [31:0] wd,
                          output logic [31:0] p_data, output logic p_err,
                          output int p_lat, output int p_t);
        int n, t, lat, w0, wl, ba, nacc;
        longint lrel;
        logic [31:0] v;
        while (cyc < free_cyc) begin
            @(posedge clk);
            #1;
        end
        req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
        req_unsigned = uns; req_wdata = wd;
        t = cyc + 1;

        n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : (size == 2'd2) ? 4 : 0;
        lrel = longint'(addr) - longint'(BASE);
        p_err = (n == 0) || (lrel < 0) || (lrel + n > 4 * DEP);
`ifndef MEM_LSU_MISALIGN_SPLIT_EN
        if (!p_err && (lrel % n) != 0) p_err = 1'b1;
`endif
        p_data = 32'h0;
        if (p_err) begin
            lat = 1;
        end else begin
            w0 = int'(lrel) / 4;
            wl = (int'(lrel) + n - 1) / 4;
            nacc = (wl != w0) ? 2 : 1;
            for (int j = 0; j < nacc; j++) begin
                int c;
                logic [3:0]  m;
                logic [31:0] d;
                c = t + ((j == 0) ? 0 : (we ? 1 : 2));
                m = 4'b0; d = 32'h0;
                for (int b = 0; b < n; b++) begin
                    ba = int'(lrel) + b;
                    if (ba / 4 == w0 + j) begin
                        m[ba % 4] = 1'b1;
                        d[8*(ba % 4) +: 8] = wd[8*b +: 8];
                    end
                end
                exp_aw[c] = 32'(w0 + j);
                exp_am[c] = we ? m : 4'b0;
                exp_ad[c] = we ? d : 32'h0;
            end
            if (we) begin
                for (int b = 0; b < n; b++) ref_mem[int'(lrel) + b] = wd[8*b +: 8];
                lat = (nacc == 2) ? 3 : 2;
            end else begin
                v = 32'h0;
                for (int b = 0; b < n; b++) v[8*b +: 8] = ref_mem[int'(lrel) + b];
                if (!uns && n < 4 && v[8*n-1]) v = v | ~((32'h1 << (8*n)) - 32'h1);
                p_data = v;
                lat = (nacc == 2) ? 5 : 3;
            end
        end
        for (int c = t; c < t + lat; c++) exp_busy[c] = 1'b1;
        exp_rv[t + lat - 1] = 1'b1;
        exp_rd[t + lat - 1] = p_data;
        exp_re[t + lat - 1] = p_err;
        free_cyc = t + lat;
        p_lat = lat;
        p_t = t;

        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    // Pull reset for the next edge; anything the model expected from then on
    // is dropped.
    task automatic mid_reset();
        int e;
        reset_n = 1'b0;
        e = cyc + 1;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int c = e; c < e + 8; c++) begin
            exp_rv.delete(c); exp_rd.delete(c); exp_re.delete(c); exp_busy.delete(c);
            exp_aw.delete(c); exp_am.delete(c); exp_ad.delete(c);
        end
        free_cyc = e;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic        e;
        int          lat, t;

        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_en_n", 32'(ram_en_n), 32'd1);
        chk("rst_addr", ram_addr, 32'd0);
        chk("rst_wdata", ram_wdata, 32'd0);
        chk("rst_mask", 32'(ram_wr_mask), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        free_cyc = cyc;
        chk_en = 1'b1;

        // Word store then word load at 0x8.
        do_req(1'b1, 32'h8, 2'b10, 1'b0, 32'hABCD_EF89, d, e, lat, t);
        chk("lit_stw_lat", 32'(lat), 32'd2);
        chk("lit_stw_word", exp_aw[t], 32'd2);
        chk("lit_stw_mask", 32'(exp_am[t]), 32'hF);
        do_req(1'b0, 32'h8, 2'b10, 1'b0, 32'h0, d, e, lat, t);
        chk("lit_ldw_data", d, 32'hABCD_EF89);
        chk("lit_ldw_lat", 32'(lat), 32'd3);

        // Byte store over 0x12345678.
        do_req(1'b1, 32'h0, 2'b10, 1'b0, 32'h1234_5678, d, e, lat, t);
        do_req(1'b1, 32'h1, 2'b00, 1'b0, 32'h0000_00FF, d, e, lat, t);
        chk("lit_stb_mask", 32'(exp_am[t]), 32'b0010);
        chk("lit_stb_lane", exp_ad[t] & 32'h0000_FF00, 32'h0000_FF00);
        do_req(1'b0, 32'h0, 2'b10, 1'b0, 32'h0, d, e, lat, t);
        chk("lit_ldw_merged", d, 32'h1234_FF78);

        // Byte loads signed / unsigned, half load signed.
        do_req(1'b0, 32'h1, 2'b00, 1'b0, 32'h0, d, e, lat, t);
        chk("lit_ldb_signed", d, 32'hFFFF_FFFF);
        do_req(1'b0, 32'h1, 2'b00, 1'b1, 32'h0, d, e, lat, t);
        chk("lit_ldb_unsigned", d, 32'h0000_00FF);
        do_req(1'b1, 32'h0, 2'b10, 1'b0, 32'h8001_1234, d, e, lat, t);
        do_req(1'b0, 32'h2, 2'b01, 1'b0, 32'h0, d, e, lat, t);
        chk("lit_ldh_signed", d, 32'hFFFF_8001);

        // Misaligned half at 0x3 straddling words 0 and 1.
        do_req(1'b1, 32'h0, 2'b10, 1'b0, 32'h1122_3344, d, e, lat, t);
        do_req(1'b1, 32'h4, 2'b10, 1'b0, 32'h5566_7788, d, e, lat, t);
        do_req(1'b0, 32'h3, 2'b01, 1'b1, 32'h0, d, e, lat, t);
`ifdef MEM_LSU_MISALIGN_SPLIT_EN
        chk("lit_ldh_split", d, 32'h0000_8811);
        chk("lit_ldh_split_lat", 32'(lat), 32'd5);
`else
        chk("lit_ldh_mis_err", 32'(e), 32'd1);
        chk("lit_ldh_mis_lat", 32'(lat), 32'd1);
`endif

        // Illegal size and out-of-range word.
        do_req(1'b0, 32'h0, 2'b11, 1'b0, 32'h0, d, e, lat, t);
        chk("lit_ill_err", 32'(e), 32'd1);
        do_req(1'b0, BASE + 32'(4 * DEP), 2'b10, 1'b0, 32'h0, d, e, lat, t);
        chk("lit_oor_err", 32'(e), 32'd1);
        do_req(1'b1, BASE + 32'(4 * DEP - 2), 2'b10, 1'b0, 32'h0, d, e, lat, t);
        chk("lit_oor_tail_err", 32'(e), 32'd1);

        // Word store at 0x6 (split store with the option, error without).
        do_req(1'b1, 32'h6, 2'b10, 1'b0, 32'hAABB_CCDD, d, e, lat, t);
        do_req(1'b0, 32'h4, 2'b10, 1'b0, 32'h0, d, e, lat, t);
`ifdef MEM_LSU_MISALIGN_SPLIT_EN
        chk("lit_split_st_lo", d, 32'hCCDD_7788);
`else
        chk("lit_mis_st_nochange", d, 32'h5566_7788);
`endif
        do_req(1'b0, 32'h8, 2'b10, 1'b0, 32'h0, d, e, lat, t);
`ifdef MEM_LSU_MISALIGN_SPLIT_EN
        chk("lit_split_st_hi", d, 32'hABCD_AABB);
`else
        chk("lit_mis_st_nochange2", d, 32'hABCD_EF89);
`endif

        // Reset while a load waits on the RAM; the next request runs normally.
        do_req(1'b0, 32'h8, 2'b10, 1'b0, 32'h0, d, e, lat, t);
        @(posedge clk);
        #1;
        mid_reset();
        do_req(1'b0, 32'h0, 2'b10, 1'b0, 32'h0, d, e, lat, t);
        chk("lit_after_reset", d, 32'h1122_3344);
        do_req(1'b0, 32'h3, 2'b00, 1'b0, 32'h0, d, e, lat, t);
        chk("lit_ldb_off3", d, 32'h0000_0011);

        while (cyc < free_cyc + 2) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk_en = 1'b0;
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Load/store unit sitting directly upstream of mem_RAM.
- Takes byte-addressed core load/store requests (byte/half/word, signed/unsigned) over a valid/ready handshake.
- Converts each request into word-indexed RAM accesses: en_n, word address, byte write mask, lane-steered write data.
- Extracts and sign/zero-extends read data, returning a single-cycle response pulse.

Parameters:
- BASE_ADDR, 32'h0000_0000: byte address mapped to RAM word 0.
- DEPTH, 1024: RAM size in 32-bit words; accesses outside [BASE_ADDR, BASE_ADDR+4*DEPTH) are errors.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  unit idle and able to accept a request.
- req_we_i  in  1  1 = store, 0 = load.
- req_addr_i  in  32  byte address.
- req_size_i  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned_i  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_wdata_i  in  32  store data, right-aligned.
- rsp_valid_o  out  1  one-cycle response pulse, no backpressure.
- rsp_rdata_o  out  32  extended load data; 0 for stores and errors.
- rsp_err_o  out  1  qualified by rsp_valid_o.
- ram_en_n_o  out  1  RAM enable, active low.
- ram_addr_o  out  32  RAM word index = (addr-BASE_ADDR)>>2, zero-extended.
- ram_wdata_o  out  32  lane-steered store data.
- ram_wr_mask_o  out  4  byte write enables; 0000 = read.
- ram_rdata_i  in  32  RAM read data, valid the cycle after the address with en_n low.

Behaviour:
- Reset (sync, reset_n=0 at a rising edge), from any state including mid-access:
  - State goes to IDLE; the in-flight request is dropped and no response is issued.
  - Outputs: req_ready_o=1, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, ram_en_n_o=1, ram_addr_o=0, ram_wdata_o=0, ram_wr_mask_o=0.
- Outside ISSUE states: ram_en_n_o=1 and ram_wr_mask_o=0000, so the RAM is never written spuriously.
- Handshake:
  - Request accepted on the edge where req_valid_i & req_ready_o.
  - req_ready_o=1 only in IDLE; all request fields are latched on accept.
- Error checks at accept:
  - size==11, or out-of-range address, or misaligned address (half: addr[0]; word: addr[1:0]!=0).
  - Any error: no RAM access, next state RESP with rsp_err_o=1.
- FSM states: IDLE, ISSUE, WAIT, RESP (plus ISSUE_HI, WAIT_HI with the optional feature).
  - IDLE -> ISSUE on accept.
  - ISSUE: en_n=0, mask/wdata driven. Store -> RESP; load -> WAIT.
  - WAIT: sample ram_rdata_i, shift right by 8*offset, extend per size/unsigned into the response register -> RESP.
  - RESP: rsp_valid_o=1 for exactly one cycle -> IDLE.
- Latency, accept edge = T:
  - Store: rsp_valid at T+2.
  - Load: rsp_valid at T+3.
  - Error: rsp_valid at T+1.
  - Back-to-back throughput: one request per 3 cycles (store), 4 cycles (load).
- Lane steering, offset = addr[1:0]:
  - Byte: mask 0001<<offset.
  - Half: mask 0011<<offset.
  - Word: mask 1111.
  - wdata = req_wdata_i << (8*offset).
- Extension: byte uses bit 7, half uses bit 15 as sign when req_unsigned_i=0.

Optional Feature:
- Macro: MEM_LSU_MISALIGN_SPLIT_EN.
- Without it: misaligned accesses are errors (as above).
- With it, misaligned accesses are legal:
  - Non-crossing case (offset + bytes ≤ 4): single access with shifted mask/data.
  - Crossing case: ISSUE (word k, mask = bytes offset..3, wdata << 8*offset) -> [WAIT] -> ISSUE_HI (word k+1, low bytes, wdata >> 8*(4-offset)) -> [WAIT_HI] -> RESP.
  - Load data is assembled from both words before extension.
  - Crossing load latency T+5, crossing store T+3.
  - Range check covers the last byte; word k+1 past DEPTH is an error with no access.

Decomposition:
- Package mem_lsu_pkg holds:
  - Size encodings SZ_BYTE/SZ_HALF/SZ_WORD/SZ_ILL.
  - FSM state enum.
  - Byte-mask constants.
- Sub-module mem_lsu_align, purely combinational:
  - Inputs: size, offset, wdata, rdata.
  - Outputs: mask, steered wdata, extracted/extended rdata.
  - Shared by both the lo and hi paths.

Test Plan:
- Word store addr 0x8, data 0xABCDEF89, then word load addr 0x8 -> RAM addr 2, mask 1111; load rsp 0xABCDEF89, err 0, rsp at T+3.
- Byte store 0xFF at addr 0x1 over word 0x12345678 -> mask 0010, wdata 0x0000FF00; word load returns 0x1234FF78.
- Byte load addr 0x1: signed -> 0xFFFFFFFF; unsigned -> 0x000000FF. Half load addr 0x2 signed over 0x8001_xxxx -> 0xFFFF8001.
- Half load addr 0x3 without macro -> rsp_err_o=1 at T+1, ram_en_n_o stays 1. With macro, over words 0x11223344 (addr 0) / 0x55667788 (addr 4) -> 0x00008811 unsigned.
- Illegal size 11, and word access at BASE_ADDR+4*DEPTH -> err 1, no RAM enable; req_ready_o low for exactly 1 cycle.
- reset_n=0 during WAIT of a load -> next cycle IDLE, ram_en_n_o=1, mask 0, no rsp_valid; a new request is accepted normally afterwards.
